// File: rtl/dsm_pkg.sv
// Shared definitions for the delta-sigma sample sequencer: sample width,
// full-scale clamp limits, sequencer state encoding and the clamp helpers.
package dsm_pkg;

    localparam int W = 20;

    localparam logic [W-1:0] VIN_FS     = 20'h0_8000;
    localparam logic [W-1:0] VIN_FS_NEG = 20'hF_8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2
    } seq_state_e;

    // True when the two's complement sample lies outside +/-VIN_FS.
    function automatic logic sample_clips(input logic [W-1:0] d);
        return ($signed(d) > $signed(VIN_FS)) || ($signed(d) < $signed(VIN_FS_NEG));
    endfunction

    // Saturates a sample to the modulator's full-scale range; endpoints pass through.
    function automatic logic [W-1:0] clamp_sample(input logic [W-1:0] d);
        if ($signed(d) > $signed(VIN_FS)) begin
            return VIN_FS;
        end
        if ($signed(d) < $signed(VIN_FS_NEG)) begin
            return VIN_FS_NEG;
        end
        return d;
    endfunction

endpackage

// File: rtl/dsm_sample_fifo.sv
// Two-entry synchronous sample buffer between the input stream and vin.
// Flush empties it in one clock and takes priority over push/pop.
module dsm_sample_fifo
    import dsm_pkg::*;
(
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] push_data,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && (count_q != 2'd2);
    assign do_pop  = pop && (count_q != 2'd0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 2'd1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 2'd1;
            end
        end
    end

endmodule

// File: rtl/dsm_sample_sequencer.sv
// Feeds DSM_top with clamped samples held for OSR clocks each, sequences the
// modulator reset around enable, and keeps underrun / clipping status.
module dsm_sample_sequencer
    import dsm_pkg::*;
#(
    parameter int OSR          = 64,
    parameter int FLUSH_CYCLES = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         enable,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic [W-1:0] vin,
    output logic         dsm_reset,
    output logic         sample_tick,
    input  logic         status_clr,
    output logic [7:0]   underrun_cnt,
    output logic         clip_flag
);

    localparam int OSR_W = $clog2(OSR);
    localparam int FL_W  = $clog2(FLUSH_CYCLES + 1);
    localparam logic [OSR_W-1:0] OSR_LAST   = OSR_W'(OSR - 1);
    localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(FLUSH_CYCLES - 1);

    seq_state_e       state_q, state_d;
    logic [OSR_W-1:0] osr_cnt_q, osr_cnt_d;
    logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [W-1:0]     vin_q, vin_d;
    logic             dsm_reset_q, dsm_reset_d;
    logic             tick_q, tick_d;
    logic [7:0]       underrun_q, underrun_d;
    logic             clip_q, clip_d;

    logic             push_accept;
    logic             load;
    logic             underrun_inc;
    logic             fifo_flush;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic [1:0]       fifo_count;
    logic [W-1:0]     fifo_head;
    logic [W-1:0]     clamped;
    logic             clip_event;

    assign s_ready      = (state_q != IDLE) && (fifo_count < 2'd2);
    assign push_accept  = s_valid && s_ready;
    assign clamped      = clamp_sample(s_data);
    assign clip_event   = push_accept && sample_clips(s_data);
    assign fifo_empty   = (fifo_count == 2'd0);

    // A sample arriving into an empty buffer on a load edge goes straight to vin.
    assign fifo_pop     = load && !fifo_empty;
    assign fifo_push    = push_accept && !(load && fifo_empty);

    assign vin          = vin_q;
    assign dsm_reset    = dsm_reset_q;
    assign sample_tick  = tick_q;
    assign underrun_cnt = underrun_q;
    assign clip_flag    = clip_q;

    dsm_sample_fifo u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .push_data (clamped),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // Sequencer state, OSR/flush counters and the registered modulator-facing outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            osr_cnt_q   <= '0;
            flush_cnt_q <= '0;
            vin_q       <= '0;
            dsm_reset_q <= 1'b1;
            tick_q      <= 1'b0;
            underrun_q  <= 8'd0;
            clip_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            osr_cnt_q   <= osr_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            vin_q       <= vin_d;
            dsm_reset_q <= dsm_reset_d;
            tick_q      <= tick_d;
            underrun_q  <= underrun_d;
            clip_q      <= clip_d;
        end
    end

    // Next-state logic: IDLE -> FLUSH on enable, FLUSH -> RUN after the flush window, any -> IDLE on stop.
    always_comb begin
        state_d      = state_q;
        osr_cnt_d    = osr_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        dsm_reset_d  = dsm_reset_q;
        vin_d        = vin_q;
        tick_d       = 1'b0;
        load         = 1'b0;
        underrun_inc = 1'b0;
        fifo_flush   = 1'b0;

        if (!enable) begin
            state_d     = IDLE;
            osr_cnt_d   = '0;
            flush_cnt_d = '0;
            dsm_reset_d = 1'b1;
            vin_d       = '0;
            fifo_flush  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                    dsm_reset_d = 1'b1;
                    vin_d       = '0;
                end
                FLUSH: begin
                    dsm_reset_d = 1'b1;
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_d     = RUN;
                        osr_cnt_d   = '0;
                        dsm_reset_d = 1'b0;
                        load        = 1'b1;
                        tick_d      = 1'b1;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    dsm_reset_d = 1'b0;
                    if (osr_cnt_q == OSR_LAST) begin
                        osr_cnt_d    = '0;
                        load         = 1'b1;
                        tick_d       = 1'b1;
                        underrun_inc = fifo_empty && !push_accept;
                    end else begin
                        osr_cnt_d = osr_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (load) begin
                if (!fifo_empty) begin
                    vin_d = fifo_head;
                end else if (push_accept) begin
                    vin_d = clamped;
                end else begin
                    vin_d = '0;
                end
            end
        end
    end

    // Status: saturating underrun count and sticky clip flag; a new event beats status_clr.
    always_comb begin
        underrun_d = underrun_q;
        clip_d     = clip_q;
        if (underrun_inc) begin
            if (status_clr) begin
                underrun_d = 8'd1;
            end else if (underrun_q != 8'hFF) begin
                underrun_d = underrun_q + 8'd1;
            end
        end else if (status_clr) begin
            underrun_d = 8'd0;
        end
        if (clip_event) begin
            clip_d = 1'b1;
        end else if (status_clr) begin
            clip_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_dsm_sample_sequencer.sv
// Randomised bench for dsm_sample_sequencer against a queue-based model that
// tracks time since enable and derives OSR boundaries arithmetically.
module tb_dsm_sample_sequencer;

    localparam int OSR   = 64;
    localparam int FLUSH = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        s_valid;
    logic        s_ready;
    logic [19:0] s_data;
    logic [19:0] vin;
    logic        dsm_reset;
    logic        sample_tick;
    logic        status_clr;
    logic [7:0]  underrun_cnt;
    logic        clip_flag;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;

    // Reference model state: tAct is clocks since entering FLUSH (-1 when idle).
    int          tAct;
    logic [19:0] mq[$];
    logic [19:0] mVin;
    logic        mTick;
    int          mUr;
    logic        mClip;
    logic        mLastAcc;

    dsm_sample_sequencer #(.OSR(OSR), .FLUSH_CYCLES(FLUSH)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .vin          (vin),
        .dsm_reset    (dsm_reset),
        .sample_tick  (sample_tick),
        .status_clr   (status_clr),
        .underrun_cnt (underrun_cnt),
        .clip_flag    (clip_flag)
    );

    always #5 clock = ~clock;

    function automatic logic [19:0] clampRef(input logic [19:0] d);
        int v;
        v = int'($signed(d));
        if (v > 32768) return 20'h08000;
        if (v < -32768) return 20'hF8000;
        return d;
    endfunction

    function automatic logic clipsRef(input logic [19:0] d);
        int v;
        v = int'($signed(d));
        return (v > 32768) || (v < -32768);
    endfunction

    function automatic logic modelReady();
        return (tAct >= 0) && (mq.size() < 2);
    endfunction

    function automatic logic [31:0] obsVec();
        return {vin, dsm_reset, s_ready, sample_tick, underrun_cnt, clip_flag};
    endfunction

    function automatic logic [31:0] expVec();
        logic rst;
        rst = (tAct < FLUSH);
        return {mVin, rst, modelReady(), mTick, 8'(mUr), mClip};
    endfunction

    function automatic logic [19:0] randSample();
        case ($urandom_range(0, 5))
            0: return 20'($urandom);
            1: return 20'($urandom_range(0, 32768));
            2: return 20'h08000;
            3: return 20'hF8000;
            4: return 20'h08001;
            default: return 20'hF7FFF;
        endcase
    endfunction

    task automatic modelReset();
        tAct = -1;
        mq.delete();
        mVin = '0;
        mTick = 1'b0;
        mUr = 0;
        mClip = 1'b0;
        mLastAcc = 1'b0;
    endtask

    // Applies one rising edge to the model using the inputs as currently driven.
    task automatic modelEdge();
        logic acc;
        logic clipEv;
        logic urEv;
        logic ld;
        acc = s_valid && modelReady();
        clipEv = acc && clipsRef(s_data);
        urEv = 1'b0;
        ld = 1'b0;
        if (!enable) begin
            tAct = -1;
            mq.delete();
            mVin = '0;
        end else if (tAct < 0) begin
            tAct = 0;
        end else begin
            if (acc) mq.push_back(clampRef(s_data));
            ld = (tAct >= FLUSH - 1) && (((tAct - (FLUSH - 1)) % OSR) == 0);
            if (ld) begin
                if (mq.size() > 0) begin
                    mVin = mq.pop_front();
                end else begin
                    mVin = '0;
                    urEv = (tAct > FLUSH - 1);
                end
            end
            tAct++;
        end
        mTick = ld;
        if (urEv) mUr = status_clr ? 1 : ((mUr < 255) ? mUr + 1 : 255);
        else if (status_clr) mUr = 0;
        if (clipEv) mClip = 1'b1;
        else if (status_clr) mClip = 1'b0;
        mLastAcc = acc;
    endtask

    task automatic advance();
        modelEdge();
        @(posedge clock);
        #1;
        cycle++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        status_clr = 1'b0;
        modelReset();
        @(posedge clock);
        #1;
        if (obsVec() !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL reset_state cyc=%0d got=%h exp=%h", cycle, obsVec(), expVec());
        end
        vectors++;
        reset_n = 1'b1;
        advance();
        if (obsVec() !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL idle_hold cyc=%0d got=%h exp=%h", cycle, obsVec(), expVec());
        end
        vectors++;
    endtask

    task automatic test_start();
        enable = 1'b1;
        for (int n = 0; n < FLUSH + 4; n++) begin
            advance();
            if (obsVec() !== expVec()) begin
                miscompares++;
                $display("[TB] FAIL start cyc=%0d got=%h exp=%h", cycle, obsVec(), expVec());
            end
            vectors++;
        end
    endtask

    task automatic test_stream();
        logic [19:0] list [3];
        int idx;
        list[0] = 20'h04000;
        list[1] = 20'hFC000;
        list[2] = 20'h00000;
        idx = 0;
        for (int n = 0; n < 4 * OSR; n++) begin
            s_valid = (idx < 3);
            s_data = (idx < 3) ? list[idx] : '0;
            advance();
            if (mLastAcc) idx++;
            if (obsVec() !== expVec()) begin
                miscompares++;
                $display("[TB] FAIL stream cyc=%0d got=%h exp=%h", cycle, obsVec(), expVec());
            end
            vectors++;
        end
        s_valid = 1'b0;
    endtask

    task automatic test_clamp();
        logic [19:0] list [3];
        int idx;
        list[0] = 20'h09000;
        list[1] = 20'hF0000;
        list[2] = 20'h08000;
        idx = 0;
        for (int n = 0; n < 6 * OSR; n++) begin
            status_clr = (n == 0) || (n == 3 * OSR);
            s_valid = (idx < 2) || (idx == 2 && n > 3 * OSR);
            s_data = (idx < 3) ? list[idx] : '0;
            advance();
            if (mLastAcc) idx++;
            if (obsVec() !== expVec()) begin
                miscompares++;
                $display("[TB] FAIL clamp cyc=%0d got=%h exp=%h", cycle, obsVec(), expVec());
            end
            vectors++;
        end
        status_clr = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic test_full();
        s_valid = 1'b1;
        s_data = randSample();
        for (int n = 0; n < 3 * OSR; n++) begin
            advance();
            if (mLastAcc) s_data = randSample();
            if (obsVec() !== expVec()) begin
                miscompares++;
                $display("[TB] FAIL full cyc=%0d got=%h exp=%h", cycle, obsVec(), expVec());
            end
            vectors++;
        end
    endtask

    task automatic test_enable_drop();
        bit armed;
        armed = 1'b0;
        s_valid = 1'b1;
        for (int n = 0; n < 3 * OSR && !armed; n++) begin
            advance();
            if (mLastAcc) s_data = randSample();
            if (obsVec() !== expVec()) begin
                miscompares++;
                $display("[TB] FAIL fill cyc=%0d got=%h exp=%h", cycle, obsVec(), expVec());
            end
            vectors++;
            armed = (mq.size() == 2) && (((tAct - FLUSH) % OSR) == OSR / 2);
        end
        if (!armed) begin
            miscompares++;
            $display("[TB] FAIL enable_drop_setup cyc=%0d got=%0d exp=2", cycle, mq.size());
        end
        vectors++;
        s_valid = 1'b0;
        enable = 1'b0;
        advance();
        if (obsVec() !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL enable_drop cyc=%0d got=%h exp=%h", cycle, obsVec(), expVec());
        end
        vectors++;
        enable = 1'b1;
        for (int n = 0; n < FLUSH + OSR + 4; n++) begin
            advance();
            if (obsVec() !== expVec()) begin
                miscompares++;
                $display("[TB] FAIL reenable cyc=%0d got=%h exp=%h", cycle, obsVec(), expVec());
            end
            vectors++;
        end
    endtask

    task automatic test_underrun();
        s_valid = 1'b0;
        for (int n = 0; n < 301 * OSR; n++) begin
            advance();
            if (obsVec() !== expVec()) begin
                miscompares++;
                $display("[TB] FAIL underrun cyc=%0d got=%h exp=%h", cycle, obsVec(), expVec());
            end
            vectors++;
        end
        if (underrun_cnt !== 8'd255) begin
            miscompares++;
            $display("[TB] FAIL underrun_saturate cyc=%0d got=%0d exp=255", cycle, underrun_cnt);
        end
        vectors++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 4000; n++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data = randSample();
            status_clr = ($urandom_range(0, 49) == 0);
            enable = ($urandom_range(0, 499) != 0);
            advance();
            if (obsVec() !== expVec()) begin
                miscompares++;
                $display("[TB] FAIL random cyc=%0d got=%h exp=%h", cycle, obsVec(), expVec());
            end
            vectors++;
        end
        s_valid = 1'b0;
        status_clr = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_reset_midrun();
        s_valid = 1'b1;
        s_data = 20'h01234;
        for (int n = 0; n < FLUSH + OSR + 5; n++) begin
            advance();
        end
        s_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        modelReset();
        if (obsVec() !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL async_reset cyc=%0d got=%h exp=%h", cycle, obsVec(), expVec());
        end
        vectors++;
        @(posedge clock);
        #1;
        if (obsVec() !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL reset_hold cyc=%0d got=%h exp=%h", cycle, obsVec(), expVec());
        end
        vectors++;
        reset_n = 1'b1;
        for (int n = 0; n < FLUSH + 4; n++) begin
            advance();
            if (obsVec() !== expVec()) begin
                miscompares++;
                $display("[TB] FAIL restart cyc=%0d got=%h exp=%h", cycle, obsVec(), expVec());
            end
            vectors++;
        end
    endtask

    // Runs every scenario in order and reports the totals.
    initial begin
        test_reset();
        test_start();
        test_stream();
        test_clamp();
        test_full();
        test_enable_drop();
        test_underrun();
        test_random();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
